hsv_frame_ctrl: RTL and testbench
=================================

// Module: hsv_frame_ctrl
// PURPOSE
//  Frame-level sequencer in front of the RGB2HSV converter: gates the pixel stream into it,
//  tracks converter in-flight beats, and swaps shadow HSV-adjust config into active registers
//  only at frame boundaries, after the previous frame has fully drained.
//  Also provides frame-length checking and a frame counter.
//  Sits between the sensor/ISP stream and RGB2HSV; active cfg feeds the HSV adjust stage.
// PARAMETERS
//  RGB_DEPTH   8   bits per RGB channel
//  HSV_DEPTH   8   bits per HSV channel / cfg word width
//  PIX_W       24  width of frame pixel count
//  PIPE_DEPTH  10  converter latency; in-flight counter sized $clog2(PIPE_DEPTH+1)
// PORTS
//  clk            in   1          clock
//  reset          in   1          synchronous, active-high
//  enable         in   1          run request; sampled at frame boundaries only
//  cfg_wr         in   1          shadow register write strobe
//  cfg_sel        in   2          0=hue_off 1=sat_gain 2=val_gain 3=reserved (ignored)
//  cfg_wdata      in   HSV_DEPTH  shadow write data
//  cfg_frame_pix  in   PIX_W      expected pixels per frame (static while enable=1)
//  s_valid/s_ready in/out 1       upstream handshake
//  s_data         in   RGB_DEPTH x3  upstream pixel; s_user in 8 (bit0=SOF, bit1=EOL)
//  m_valid/m_ready out/in 1       to converter in_valid / from converter out_ready
//  m_data, m_user out  as s_*     to converter
//  mon_valid,mon_ready in 1       tap of converter output handshake (out_valid, downstream ready)
//  act_hue_off, act_sat_gain, act_val_gain  out  HSV_DEPTH  active config
//  busy           out  1          state != IDLE
//  frame_done     out  1          1-cycle pulse on last pixel of frame accepted
//  err_len        out  1          sticky length/sync error; err_clr in 1 clears
//  frame_cnt      out  16         frames started (wraps 0xFFFF->0)
// BEHAVIOUR
//  - Reset: state IDLE; s_ready=0, m_valid=0, busy=0, frame_done=0, err_len=0, frame_cnt=0,
//    inflight=0, pix_cnt=0; shadow+active: hue_off=0, sat_gain=val_gain=1<<(HSV_DEPTH-1) (1.0 Q1.x).
//  - Zero-latency passthrough: m_data/m_user=s_data/s_user; m_valid=s_valid&pass;
//    s_ready=(m_ready&pass)|drop. pass=(state==RUN). drop: see WAIT_SOF.
//  - States:
//    IDLE:     s_ready=0. enable=1 -> WAIT_SOF.
//    WAIT_SOF: enable=0 -> IDLE. Non-SOF beats dropped (s_ready=1, m_valid=0); each drop sets
//              err_len if frame_cnt!=0. SOF beat present -> DRAIN, held (s_ready=0).
//    DRAIN:    s_ready=0; inflight==0 -> SWAP.
//    SWAP:     1 cycle; active<=shadow, frame_cnt++, pix_cnt<=0 -> RUN.
//    RUN:      accepted beat pix_cnt++; beat with pix_cnt==cfg_frame_pix-1 accepted:
//              frame_done=1 -> WAIT_SOF. SOF beat at pix_cnt!=0: not accepted, err_len=1,
//              -> DRAIN (short frame; new frame handled normally).
//  - inflight: +1 on m_valid&m_ready, -1 on mon_valid&mon_ready, both -> unchanged.
//    Never exceeds PIPE_DEPTH; never underflows (assertion).
//  - cfg_wr writes shadow in any state; write in SWAP cycle not seen until next SWAP.
//  - err_clr and error set same cycle: set wins.
//  - enable drop during RUN: frame completes, then IDLE from WAIT_SOF.
//  - cfg_frame_pix==0 treated as 1.
//  - Reset mid-frame: all state to reset values; converter reset from same signal.
// STRUCTURE
//  - Package hsv_pkg: state enum (IDLE,WAIT_SOF,DRAIN,SWAP,RUN), CFG_SEL_* constants,
//    USER_SOF=0/USER_EOL=1, GAIN_UNITY.
//  - Sub-module hsv_inflight_cnt: up/down counter, params WIDTH, MAX; assertion on bounds.
//  - Top: FSM, pixel counter, shadow/active regs, flags.
// TESTING
//  1 Reset, enable=1, cfg_frame_pix=16, send 16-beat frame (SOF on beat 0) -> all 16 reach m_*,
//    frame_done on beat 15, frame_cnt=1, busy=1.
//  2 cfg_wr sat_gain=0x40 mid-frame -> act_sat_gain stays 0x80 until next SOF; SWAP only after
//    inflight reaches 0 (10 cycles with converter), then 0x40.
//  3 Downstream stalls (mon_ready=0) while next SOF waits -> s_ready=0 held in DRAIN;
//    no beat of frame 2 enters before inflight==0.
//  4 Frame of 10 beats then SOF (cfg 16) -> err_len=1, new frame accepted, frame_cnt increments;
//    err_clr -> err_len=0.
//  5 Start stream mid-frame (no SOF) -> beats dropped, s_ready=1, m_valid=0, err_len stays 0.
//  6 Reset asserted mid-RUN with 5 in flight -> next cycle IDLE, inflight=0, defaults restored.

Source files
------------

// File: rtl/hsv_frame_ctrl_pkg.sv
// Shared types and constants for the RGB2HSV frame sequencer.
// Imported by the frame controller and its testbench.
package hsv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_SOF,
      ST_DRAIN,
      ST_SWAP,
      ST_RUN
   } state_e;

   localparam logic [1:0] CFG_SEL_HUE = 2'd0;
   localparam logic [1:0] CFG_SEL_SAT = 2'd1;
   localparam logic [1:0] CFG_SEL_VAL = 2'd2;
   localparam logic [1:0] CFG_SEL_RSV = 2'd3;

   localparam int USER_SOF = 0;
   localparam int USER_EOL = 1;

   // 1.0 in Q1.(w-1): gains reset to unity
   function automatic logic [31:0] gain_unity(input int w);
      return 32'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/hsv_frame_ctrl_if.sv
// Valid/ready pixel stream bundle (data + sideband user bits).
// master drives the beat, slave returns ready.
interface hsv_frame_ctrl_if #(
   parameter int DW = 24,
   parameter int UW = 8
);
   logic          valid;
   logic          ready;
   logic [DW-1:0] data;
   logic [UW-1:0] user;

   modport master (output valid, data, user, input ready);
   modport slave  (input valid, data, user, output ready);
endinterface

// File: rtl/hsv_frame_ctrl_inflight_cnt.sv
// Up/down count of beats inside the converter pipeline.
// Bounds are checked so a broken converter tap is caught early.
module hsv_inflight_cnt #(
   parameter int WIDTH = 4,
   parameter int MAX   = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic             zero_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   // simultaneous in and out leaves the count unchanged
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && !dec_i)
         cnt_d = cnt_q + WIDTH'(1);
      else if (dec_i && !inc_i)
         cnt_d = cnt_q - WIDTH'(1);
   end

   // count register
   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);

   a_no_underflow: assert property (@(posedge clk) disable iff (reset)
      !(dec_i && !inc_i && cnt_q == '0));

   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(inc_i && !dec_i && cnt_q == WIDTH'(MAX)));

endmodule

// File: rtl/hsv_frame_ctrl.sv
// Frame sequencer in front of RGB2HSV: gates the stream, waits
// for the converter to drain, then swaps shadow cfg at each SOF.
module hsv_frame_ctrl
   import hsv_pkg::*;
#(
   parameter int RGB_DEPTH  = 8,
   parameter int HSV_DEPTH  = 8,
   parameter int PIX_W      = 24,
   parameter int PIPE_DEPTH = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable_i,
   input  logic                 cfg_wr_i,
   input  logic [1:0]           cfg_sel_i,
   input  logic [HSV_DEPTH-1:0] cfg_wdata_i,
   input  logic [PIX_W-1:0]     cfg_frame_pix_i,
   hsv_frame_ctrl_if.slave      s,
   hsv_frame_ctrl_if.master     m,
   input  logic                 mon_valid_i,
   input  logic                 mon_ready_i,
   input  logic                 err_clr_i,
   output logic [HSV_DEPTH-1:0] act_hue_off_o,
   output logic [HSV_DEPTH-1:0] act_sat_gain_o,
   output logic [HSV_DEPTH-1:0] act_val_gain_o,
   output logic                 busy_o,
   output logic                 frame_done_o,
   output logic                 err_len_o,
   output logic [15:0]          frame_cnt_o
);

   localparam int CW = $clog2(PIPE_DEPTH + 1);
   localparam logic [HSV_DEPTH-1:0] GAIN_UNITY =
      HSV_DEPTH'(gain_unity(HSV_DEPTH));

   state_e                 state_q, state_d;
   logic [PIX_W-1:0]       pix_q, pix_d, pix_last;
   logic [15:0]            fcnt_q, fcnt_d;
   logic                   err_q, err_d;
   logic [HSV_DEPTH-1:0]   sh_hue_q, sh_sat_q, sh_val_q;
   logic [HSV_DEPTH-1:0]   sh_hue_d, sh_sat_d, sh_val_d;
   logic [HSV_DEPTH-1:0]   ac_hue_q, ac_sat_q, ac_val_q;
   logic [HSV_DEPTH-1:0]   ac_hue_d, ac_sat_d, ac_val_d;
   logic [3*RGB_DEPTH-1:0] pix_data;
   logic [CW-1:0]          inflight;
   logic                   inflight_zero;
   logic                   sof, pass, drop, swap, err_set, done;
   logic                   m_fire;

   assign sof      = s.user[USER_SOF];
   assign pix_data = s.data;
   assign pix_last = (cfg_frame_pix_i == '0) ? '0
                                             : cfg_frame_pix_i - PIX_W'(1);

   assign m.data  = pix_data;
   assign m.user  = s.user;
   assign m.valid = s.valid & pass;
   assign s.ready = (m.ready & pass) | drop;
   assign m_fire  = m.valid & m.ready;

   hsv_inflight_cnt #(
      .WIDTH (CW),
      .MAX   (PIPE_DEPTH)
   ) u_inflight (
      .clk    (clk),
      .reset  (reset),
      .inc_i  (m_fire),
      .dec_i  (mon_valid_i & mon_ready_i),
      .cnt_o  (inflight),
      .zero_o (inflight_zero)
   );

   // frame FSM: next state plus stream gating strobes
   always_comb begin
      state_d = state_q;
      pass    = 1'b0;
      drop    = 1'b0;
      swap    = 1'b0;
      err_set = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (enable_i)
               state_d = ST_WAIT_SOF;
         end
         ST_WAIT_SOF: begin
            if (!enable_i) begin
               state_d = ST_IDLE;
            end else if (s.valid && sof) begin
               state_d = ST_DRAIN;
            end else begin
               drop    = 1'b1;
               err_set = s.valid && (fcnt_q != '0);
            end
         end
         ST_DRAIN: begin
            if (inflight_zero)
               state_d = ST_SWAP;
         end
         ST_SWAP: begin
            swap    = 1'b1;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (s.valid && sof && pix_q != '0) begin
               err_set = 1'b1;
               state_d = ST_DRAIN;
            end else begin
               pass = 1'b1;
               if (s.valid && m.ready && pix_q == pix_last) begin
                  done    = 1'b1;
                  state_d = ST_WAIT_SOF;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // counters, sticky error, shadow writes and frame-boundary swap
   always_comb begin
      pix_d    = pix_q;
      fcnt_d   = fcnt_q;
      err_d    = err_q;
      sh_hue_d = sh_hue_q;
      sh_sat_d = sh_sat_q;
      sh_val_d = sh_val_q;
      ac_hue_d = ac_hue_q;
      ac_sat_d = ac_sat_q;
      ac_val_d = ac_val_q;
      if (swap)
         pix_d = '0;
      else if (m_fire)
         pix_d = pix_q + PIX_W'(1);
      if (swap) begin
         fcnt_d   = fcnt_q + 16'd1;
         ac_hue_d = sh_hue_q;
         ac_sat_d = sh_sat_q;
         ac_val_d = sh_val_q;
      end
      if (err_set)
         err_d = 1'b1;
      else if (err_clr_i)
         err_d = 1'b0;
      if (cfg_wr_i) begin
         case (cfg_sel_i)
            CFG_SEL_HUE: sh_hue_d = cfg_wdata_i;
            CFG_SEL_SAT: sh_sat_d = cfg_wdata_i;
            CFG_SEL_VAL: sh_val_d = cfg_wdata_i;
            default:     ;
         endcase
      end
   end

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         pix_q    <= '0;
         fcnt_q   <= '0;
         err_q    <= 1'b0;
         sh_hue_q <= '0;
         sh_sat_q <= GAIN_UNITY;
         sh_val_q <= GAIN_UNITY;
         ac_hue_q <= '0;
         ac_sat_q <= GAIN_UNITY;
         ac_val_q <= GAIN_UNITY;
      end else begin
         state_q  <= state_d;
         pix_q    <= pix_d;
         fcnt_q   <= fcnt_d;
         err_q    <= err_d;
         sh_hue_q <= sh_hue_d;
         sh_sat_q <= sh_sat_d;
         sh_val_q <= sh_val_d;
         ac_hue_q <= ac_hue_d;
         ac_sat_q <= ac_sat_d;
         ac_val_q <= ac_val_d;
      end
   end

   assign act_hue_off_o  = ac_hue_q;
   assign act_sat_gain_o = ac_sat_q;
   assign act_val_gain_o = ac_val_q;
   assign busy_o         = (state_q != ST_IDLE);
   assign frame_done_o   = done;
   assign err_len_o      = err_q;
   assign frame_cnt_o    = fcnt_q;

endmodule

// File: tb/tb_hsv_frame_ctrl.sv
// Directed bench for hsv_frame_ctrl with a stall-all converter model
// and a scoreboard checking every beat handed to the converter.
module tb_hsv_frame_ctrl;
   import hsv_pkg::*;

   localparam int PD = 10;

   typedef struct packed {
      logic [23:0] d;
      logic [7:0]  u;
      logic        done;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        cfg_wr = 1'b0;
   logic [1:0]  cfg_sel = 2'd0;
   logic [7:0]  cfg_wdata = 8'd0;
   logic [23:0] cfg_frame_pix = 24'd16;
   logic        err_clr = 1'b0;
   logic        down_ready = 1'b1;
   logic [7:0]  act_hue, act_sat, act_val;
   logic        busy, frame_done, err_len;
   logic [15:0] frame_cnt;
   logic [PD-1:0] pv;
   logic        conv_stall;
   int          ncmp = 0;
   int          nerr = 0;
   exp_t        q[$];

   hsv_frame_ctrl_if #(.DW(24), .UW(8)) s_if ();
   hsv_frame_ctrl_if #(.DW(24), .UW(8)) m_if ();

   hsv_frame_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .enable_i        (enable),
      .cfg_wr_i        (cfg_wr),
      .cfg_sel_i       (cfg_sel),
      .cfg_wdata_i     (cfg_wdata),
      .cfg_frame_pix_i (cfg_frame_pix),
      .s               (s_if),
      .m               (m_if),
      .mon_valid_i     (pv[PD-1]),
      .mon_ready_i     (down_ready),
      .err_clr_i       (err_clr),
      .act_hue_off_o   (act_hue),
      .act_sat_gain_o  (act_sat),
      .act_val_gain_o  (act_val),
      .busy_o          (busy),
      .frame_done_o    (frame_done),
      .err_len_o       (err_len),
      .frame_cnt_o     (frame_cnt)
   );

   always #5 clk = ~clk;

   // converter: fixed 10-stage pipe that stalls as a whole
   assign conv_stall = pv[PD-1] & ~down_ready;
   assign m_if.ready = ~conv_stall;

   always @(posedge clk) begin
      if (reset)
         pv <= '0;
      else if (!conv_stall)
         pv <= {pv[PD-2:0], m_if.valid & m_if.ready};
   end

   // scoreboard monitor on the converter input
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         ncmp++;
         if (m_if.valid && m_if.ready) begin
            if (q.size() == 0) begin
               nerr++;
               $display("FAIL beat_unexpected: got data %06h, wanted no beat",
                        m_if.data);
            end else begin
               e = q.pop_front();
               if (m_if.data !== e.d || m_if.user !== e.u ||
                   frame_done !== e.done) begin
                  nerr++;
                  $display("FAIL beat: got %06h/%02h/done%0b wanted %06h/%02h/done%0b",
                           m_if.data, m_if.user, frame_done, e.d, e.u, e.done);
               end
            end
         end else if (frame_done !== 1'b0) begin
            nerr++;
            $display("FAIL done_spurious: got %0b wanted 0", frame_done);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: still running, wanted finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h wanted %0h", nm, act, exp);
      end
   endtask

   function automatic logic [23:0] pix(input int f, input int i);
      return 24'(f * 4096 + i * 17 + 'h300000);
   endfunction

   task automatic present(input logic [23:0] d, input logic [7:0] u);
      s_if.valid = 1'b1;
      s_if.data  = d;
      s_if.user  = u;
   endtask

   task automatic wait_acc();
      int n;
      bit got;
      n = 0;
      got = 0;
      while (!got && n < 300) begin
         @(negedge clk);
         if (s_if.ready === 1'b1) got = 1;
         else n++;
      end
      if (got) begin
         @(posedge clk);
         #1;
      end else begin
         ncmp++;
         nerr++;
         $display("FAIL accept_timeout: ready stayed 0, wanted 1");
      end
      s_if.valid = 1'b0;
   endtask

   task automatic send(input logic [23:0] d, input logic [7:0] u,
                       input logic done, input bit pass);
      if (pass) q.push_back('{d, u, done});
      present(d, u);
      wait_acc();
   endtask

   task automatic send_frame(input int f, input int first, input int last,
                             input int eff);
      logic [7:0] u;
      for (int i = first; i <= last; i++) begin
         u = 8'h00;
         if (i == 0) u[USER_SOF] = 1'b1;
         if (i == last) u[USER_EOL] = 1'b1;
         send(pix(f, i), u, (i == eff - 1), 1'b1);
      end
   endtask

   task automatic cfg(input logic [1:0] sel, input logic [7:0] v);
      cfg_wr    = 1'b1;
      cfg_sel   = sel;
      cfg_wdata = v;
      @(posedge clk);
      #1;
      cfg_wr = 1'b0;
   endtask

   initial begin
      bit ok;
      int n;
      s_if.valid = 1'b0;
      s_if.data  = '0;
      s_if.user  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_s_ready", s_if.ready, 0);
      chk("rst_m_valid", m_if.valid, 0);
      chk("rst_cnt", frame_cnt, 0);
      chk("rst_err", err_len, 0);
      chk("rst_sat", act_sat, 8'h80);
      chk("rst_val", act_val, 8'h80);
      chk("rst_hue", act_hue, 8'h00);
      @(posedge clk);
      #1;
      reset  = 1'b0;
      enable = 1'b1;

      // T1: one clean 16-beat frame
      send_frame(1, 0, 15, 16);
      chk("t1_cnt", frame_cnt, 1);
      chk("t1_busy", busy, 1);

      // T2: shadow writes mid-frame, swap waits for drain
      send_frame(2, 0, 5, 16);
      cfg(CFG_SEL_SAT, 8'h40);
      cfg(CFG_SEL_HUE, 8'h33);
      cfg(CFG_SEL_RSV, 8'hFF);
      send_frame(2, 6, 15, 16);
      chk("t2_sat_hold", act_sat, 8'h80);
      chk("t2_cnt", frame_cnt, 2);
      q.push_back('{pix(3, 0), 8'h01, 1'b0});
      present(pix(3, 0), 8'h01);
      ok = 1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (s_if.ready !== 1'b0 || act_sat !== 8'h80) ok = 0;
      end while ($countones(pv) != 0 && n < 100);
      chk("t2_drain_hold", 32'(ok), 1);
      chk("t2_drain_cycles", n, 11);
      wait_acc();
      chk("t2_sat_swap", act_sat, 8'h40);
      chk("t2_hue_swap", act_hue, 8'h33);
      chk("t2_val_rsv", act_val, 8'h80);
      chk("t2_cnt3", frame_cnt, 3);
      send_frame(3, 1, 15, 16);

      // T3: downstream stall keeps the next SOF out
      down_ready = 1'b0;
      q.push_back('{pix(4, 0), 8'h01, 1'b0});
      present(pix(4, 0), 8'h01);
      ok = 1;
      repeat (20) begin
         @(negedge clk);
         if (s_if.ready !== 1'b0 || m_if.valid !== 1'b0) ok = 0;
      end
      chk("t3_stall_hold", 32'(ok), 1);
      chk("t3_inflight", 32'(dut.inflight), 10);
      down_ready = 1'b1;
      wait_acc();
      chk("t3_cnt", frame_cnt, 4);

      // T4: short frame of 10 followed by SOF
      send_frame(4, 1, 9, 16);
      chk("t4_err_pre", err_len, 0);
      send(pix(5, 0), 8'h01, 1'b0, 1'b1);
      chk("t4_err", err_len, 1);
      chk("t4_cnt", frame_cnt, 5);
      send_frame(5, 1, 15, 16);
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      chk("t4_err_clr", err_len, 0);

      // frame length 0 behaves as 1
      cfg_frame_pix = 24'd0;
      send(pix(6, 0), 8'h03, 1'b1, 1'b1);
      send(pix(7, 0), 8'h03, 1'b1, 1'b1);
      chk("len0_cnt", frame_cnt, 7);
      chk("len0_err", err_len, 0);
      enable = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("dis_idle", busy, 0);

      // T6: reset with 5 beats in flight
      cfg_frame_pix = 24'd16;
      enable = 1'b1;
      send_frame(8, 0, 4, 16);
      chk("t6_inflight", 32'(dut.inflight), 5);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("t6_busy", busy, 0);
      chk("t6_inflight0", 32'(dut.inflight), 0);
      chk("t6_cnt", frame_cnt, 0);
      chk("t6_sat", act_sat, 8'h80);
      chk("t6_hue", act_hue, 8'h00);
      chk("t6_s_ready", s_if.ready, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // T5: stream joins mid-frame, beats dropped silently
      cfg_frame_pix = 24'd4;
      for (int i = 0; i < 3; i++)
         send(pix(0, i), 8'h00, 1'b0, 1'b0);
      chk("t5_err", err_len, 0);
      chk("t5_cnt", frame_cnt, 0);
      send_frame(9, 0, 3, 4);
      chk("t5_cnt1", frame_cnt, 1);
      chk("t5_sat_dflt", act_sat, 8'h80);
      send(pix(9, 9), 8'h00, 1'b0, 1'b0);
      chk("t5_drop_err", err_len, 1);

      repeat (3) @(posedge clk);
      chk("sb_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
